int_ram_ctrl: RTL



---
 rtl/ldpc_mem_pkg.sv | 16 +
 rtl/int_ram_addr_cnt.sv | 28 ++
 rtl/int_ram_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/ldpc_mem_pkg.sv
// Shared definitions for the LDPC decoder intermediate-message memory path.
package ldpc_mem_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 5;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 8;

    // Selects one of the two ping-pong banks.
    typedef logic bank_t;

    // Round-robin pointer: which side wins the next contested cycle.
    typedef enum logic {
        WR = 1'b0,
        RD = 1'b1
    } prio_t;

endpackage

// File: rtl/int_ram_addr_cnt.sv
// Modulo-FRAME_LEN address counter with enable and terminal-count flag.
module int_ram_addr_cnt
    import ldpc_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned FRAME_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] cnt,
    output logic                  tc
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_LEN - 1);

    assign tc = (cnt == LAST);

    // Advance on enable, wrapping to zero after the final word of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/int_ram_ctrl.sv
// Ping-pong controller driving the single shared port of the dual-bank
// intermediate-message RAM: producer fills one bank, consumer drains the other.
module int_ram_ctrl
    import ldpc_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned FRAME_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    output logic                  rd_gnt,
    output logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic [1:0]            bank_full,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_we,
    output logic                  ram_cs,
    output logic                  ram_rs,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    if (FRAME_LEN < 1 || 64'(FRAME_LEN) > (64'(1) << ADDR_WIDTH)) begin : g_bad_frame_len
        $error("int_ram_ctrl: FRAME_LEN must lie in 1 .. 2**ADDR_WIDTH");
    end

    bank_t                 wr_bank;
    bank_t                 rd_bank;
    prio_t                 prio;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic                  wr_tc;
    logic                  rd_tc;
    logic                  wr_space;
    logic                  rd_avail;
    logic                  wr_fire;
    logic                  contest;

    assign wr_space = !bank_full[wr_bank];
    assign rd_avail = bank_full[rd_bank];

    // Both grants are mutually exclusive: when both sides are eligible only
    // the side named by prio can pass its term.
    assign wr_ready = wr_space & (!(rd_req & rd_avail) | (prio == WR));
    assign rd_gnt   = rd_req & rd_avail & (!(wr_valid & wr_space) | (prio == RD));
    assign wr_fire  = wr_valid & wr_ready;
    assign contest  = wr_valid & wr_space & rd_req & rd_avail;

    assign rd_data = ram_data_out;

    int_ram_addr_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .FRAME_LEN  (FRAME_LEN)
    ) u_wr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_fire),
        .cnt   (wr_cnt),
        .tc    (wr_tc)
    );

    int_ram_addr_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .FRAME_LEN  (FRAME_LEN)
    ) u_rd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rd_gnt),
        .cnt   (rd_cnt),
        .tc    (rd_tc)
    );

    // Drive the RAM port; address/bank/data default to the write side when idle.
    always_comb begin
        ram_cs      = wr_fire | rd_gnt;
        ram_we      = wr_fire;
        ram_rs      = wr_bank;
        ram_address = wr_cnt;
        ram_data_in = wr_data;
        if (rd_gnt) begin
            ram_rs      = rd_bank;
            ram_address = rd_cnt;
        end
    end

    // Bank ownership, full flags, round-robin pointer and read-side strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            bank_full     <= '0;
            prio          <= WR;
            rd_data_valid <= 1'b0;
            rd_last       <= 1'b0;
        end else begin
            rd_data_valid <= rd_gnt;
            rd_last       <= rd_gnt & rd_tc;
            if (contest) begin
                prio <= wr_fire ? RD : WR;
            end
            if (wr_fire && wr_tc) begin
                bank_full[wr_bank] <= 1'b1;
                wr_bank            <= ~wr_bank;
            end
            if (rd_gnt && rd_tc) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= ~rd_bank;
            end
        end
    end

endmodule
